// File: rtl/fft_stage_sequencer_if.sv
// Handshake bundle between the FFT stage sequencer and its host/memory side.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface fft_stage_sequencer_if #(
  parameter int unsigned N_LOG2 = 8
);
  localparam int unsigned AW = N_LOG2;
  localparam int unsigned TW = N_LOG2 - 1;
  localparam int unsigned SW = $clog2(N_LOG2);

  logic          start;
  logic          abort;
  logic          mem_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [TW-1:0] tw_addr;
  logic [SW-1:0] stage_idx;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, mem_ready,
    input  rd_en, rd_addr_a, rd_addr_b, tw_addr, stage_idx,
    input  wr_en, wr_addr_a, wr_addr_b, busy, done
  );

  modport slave (
    input  start, abort, mem_ready,
    output rd_en, rd_addr_a, rd_addr_b, tw_addr, stage_idx,
    output wr_en, wr_addr_a, wr_addr_b, busy, done
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT in-place FFT address sequencer: issues butterfly reads stage by stage,
// tracks writebacks through a fixed-latency delay line and fences each stage.
module fft_stage_sequencer #(
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned N_LOG2   = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  fft_stage_sequencer_if.slave bus
);
  localparam int unsigned AW         = N_LOG2;
  localparam int unsigned TW         = N_LOG2 - 1;
  localparam int unsigned KW         = N_LOG2 - 1;
  localparam int unsigned SW         = $clog2(N_LOG2);
  localparam int unsigned SHW        = SW + 1;
  localparam int unsigned IFW        = $clog2(PIPE_LAT + 1) + 1;
  localparam int unsigned LAST_K     = (1 << KW) - 1;
  localparam int unsigned LAST_STAGE = N_LOG2 - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state;
  logic [SW-1:0]                stage;
  logic [KW-1:0]                k;
  logic [IFW-1:0]               inflight;
  logic [PIPE_LAT-1:0]          dl_v;
  logic [PIPE_LAT-1:0][AW-1:0]  dl_a;
  logic [PIPE_LAT-1:0][AW-1:0]  dl_b;
  logic [AW-1:0]                last_a;
  logic [AW-1:0]                last_b;
  logic [TW-1:0]                last_tw;
  logic                         busy_q;
  logic                         done_q;

  logic                         issue;
  logic [AW-1:0]                half;
  logic [KW-1:0]                pos;
  logic [KW-1:0]                grp;
  logic [SHW-1:0]               sh_up;
  logic [SHW-1:0]               sh_tw;
  logic [AW-1:0]                cur_a;
  logic [AW-1:0]                cur_b;
  logic [TW-1:0]                cur_tw;

  // Butterfly k of stage s: insert a zero bit at position s of k for the upper operand.
  always_comb begin
    half   = AW'(1) << stage;
    pos    = k & KW'(half - AW'(1));
    grp    = k >> stage;
    sh_up  = SHW'(stage) + SHW'(1);
    sh_tw  = SHW'(TW) - SHW'(stage);
    cur_a  = (AW'(grp) << sh_up) | AW'(pos);
    cur_b  = cur_a + half;
    cur_tw = TW'(pos) << sh_tw;
  end

  assign issue = (state == RUN) && bus.mem_ready;

  // Read side follows mem_ready in the same cycle; idle cycles replay the last issue.
  assign bus.rd_en     = issue;
  assign bus.rd_addr_a = issue ? cur_a  : last_a;
  assign bus.rd_addr_b = issue ? cur_b  : last_b;
  assign bus.tw_addr   = issue ? cur_tw : last_tw;
  assign bus.stage_idx = stage;
  assign bus.wr_en     = dl_v[PIPE_LAT-1];
  assign bus.wr_addr_a = dl_a[PIPE_LAT-1];
  assign bus.wr_addr_b = dl_b[PIPE_LAT-1];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      stage    <= '0;
      k        <= '0;
      inflight <= '0;
      dl_v     <= '0;
      dl_a     <= '0;
      dl_b     <= '0;
      last_a   <= '0;
      last_b   <= '0;
      last_tw  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Writeback delay line free-runs regardless of memory back-pressure.
      dl_v[0] <= issue;
      dl_a[0] <= cur_a;
      dl_b[0] <= cur_b;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
        dl_b[i] <= dl_b[i-1];
      end

      if (issue && !bus.wr_en) begin
        inflight <= inflight + IFW'(1);
      end else if (!issue && bus.wr_en) begin
        inflight <= inflight - IFW'(1);
      end

      if (issue) begin
        k       <= k + KW'(1);
        last_a  <= cur_a;
        last_b  <= cur_b;
        last_tw <= cur_tw;
      end

      done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            stage  <= '0;
            k      <= '0;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (issue && (k == KW'(LAST_K))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Next stage reads only after every write of this stage has landed.
          if (inflight == '0) begin
            if (stage == SW'(LAST_STAGE)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              stage <= stage + SW'(1);
              state <= RUN;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase

      if (bus.abort && (state != IDLE)) begin
        state    <= IDLE;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        inflight <= '0;
        dl_v     <= '0;
        k        <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: an arithmetic FFT address model feeds
// expected reads; observed reads schedule expected writebacks PIPE_LAT cycles later.
module tb_fft_stage_sequencer;
  localparam int unsigned PIPE_LAT = 4;
  localparam int unsigned N_LOG2   = 8;
  localparam int unsigned NBF      = 1 << (N_LOG2 - 1);
  localparam int unsigned DONE_REL = 1 + (N_LOG2 - 1) * (NBF - 1 + PIPE_LAT + 2) + (NBF - 1) + PIPE_LAT + 2;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] tw;
  } rd_t;

  typedef struct packed {
    logic [2:0]  st;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] due;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.N_LOG2(N_LOG2)) bus ();

  fft_stage_sequencer #(.PIPE_LAT(PIPE_LAT), .N_LOG2(N_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  rd_t         exp_rd[$];
  wr_t         exp_wr[$];
  rd_t         e;
  wr_t         w;
  int unsigned cyc = 0;
  int          nvec = 0;
  int          nmis = 0;
  bit          mem_mode = 1'b0;
  bit          nostall = 1'b1;
  bit          chk_idle_next = 1'b0;
  logic [3:0]  cur_stage = 4'd8;
  logic [7:0]  last_a = '0;
  logic [7:0]  last_b = '0;
  logic [6:0]  last_tw = '0;
  int unsigned last_wr_cyc = 0;
  int unsigned last_rd_cyc = 0;
  int unsigned t0 = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference transform: pairs are (j, j+half) with j having bit s clear, in ascending k.
  task automatic push_transform();
    int half;
    int pos;
    int a;
    rd_t r;
    for (int s = 0; s < int'(N_LOG2); s++) begin
      half = 1 << s;
      for (int kk = 0; kk < int'(NBF); kk++) begin
        pos  = kk % half;
        a    = (kk / half) * 2 * half + pos;
        r.st = 3'(s);
        r.a  = 8'(a);
        r.b  = 8'(a + half);
        r.tw = 7'(pos * (int'(NBF) / half));
        exp_rd.push_back(r);
      end
    end
  endtask

  task automatic start_transform();
    push_transform();
    rd_cnt    = 0;
    wr_cnt    = 0;
    done_cnt  = 0;
    cur_stage = 4'd8;
    nostall   = !mem_mode;
    t0        = cyc;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    chk("rd_total", 32'(rd_cnt), 32'd1024);
    chk("wr_total", 32'(wr_cnt), 32'd1024);
    chk("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_rd_a"}, 32'(bus.rd_addr_a), 0);
    chk({tag, "_rd_b"}, 32'(bus.rd_addr_b), 0);
    chk({tag, "_tw"}, 32'(bus.tw_addr), 0);
    chk({tag, "_wr_a"}, 32'(bus.wr_addr_a), 0);
    chk({tag, "_wr_b"}, 32'(bus.wr_addr_b), 0);
    chk({tag, "_stage"}, 32'(bus.stage_idx), 0);
  endtask

  // Memory back-pressure: always ready, or roughly 30% stalled.
  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.mem_ready = mem_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a read, write or done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_idle_next) begin
        chk("busy_after_done", 32'(bus.busy), 0);
        chk("done_one_cycle", 32'(bus.done), 0);
        chk_idle_next = 1'b0;
      end
      if (bus.rd_en) begin
        chk("rd_expected", 32'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          chk("rd_stage", 32'(bus.stage_idx), 32'(e.st));
          chk("rd_addr_a", 32'(bus.rd_addr_a), 32'(e.a));
          chk("rd_addr_b", 32'(bus.rd_addr_b), 32'(e.b));
          chk("tw_addr", 32'(bus.tw_addr), 32'(e.tw));
          if ({1'b0, e.st} != cur_stage) begin
            if (cur_stage != 4'd8) begin
              chk("stage_barrier", 32'(cyc > last_wr_cyc), 1);
              if (nostall) chk("stage_gap", cyc - last_rd_cyc, PIPE_LAT + 2);
            end else if (nostall) begin
              chk("first_issue_lat", cyc - t0, 1);
            end
            cur_stage = {1'b0, e.st};
          end
          last_a      = e.a;
          last_b      = e.b;
          last_tw     = e.tw;
          last_rd_cyc = cyc;
          w.st  = e.st;
          w.a   = e.a;
          w.b   = e.b;
          w.due = cyc + PIPE_LAT;
          exp_wr.push_back(w);
          rd_cnt++;
        end
      end else begin
        chk("hold_rd_a", 32'(bus.rd_addr_a), 32'(last_a));
        chk("hold_rd_b", 32'(bus.rd_addr_b), 32'(last_b));
        chk("hold_tw", 32'(bus.tw_addr), 32'(last_tw));
      end
      if (bus.wr_en) begin
        chk("wr_expected", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          chk("wr_addr_a", 32'(bus.wr_addr_a), 32'(w.a));
          chk("wr_addr_b", 32'(bus.wr_addr_b), 32'(w.b));
          chk("wr_latency", cyc, w.due);
          chk("wr_no_overlap", 32'(cur_stage), 32'(w.st));
          last_wr_cyc = cyc;
          wr_cnt++;
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_after_last_wr", cyc, last_wr_cyc + 2);
        chk("done_rd_drained", 32'(exp_rd.size()), 0);
        chk("done_wr_drained", 32'(exp_wr.size()), 0);
        if (nostall) chk("done_cycle", cyc - t0, DONE_REL);
        chk_idle_next = 1'b1;
      end
    end
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unstalled full transform.
    start_transform();
    wait_done(3000);

    // Random back-pressure plus a spurious start while busy.
    mem_mode = 1'b1;
    @(posedge clk); #1;
    start_transform();
    repeat (300) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(6000);

    // Abort in stage-4 drain with three operations outstanding.
    mem_mode = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start_transform();
    n = 0;
    while (!(rd_cnt == 5 * int'(NBF) && (rd_cnt - wr_cnt) == 3) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_point_reached", 32'(rd_cnt - wr_cnt), 3);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_rd_en", 32'(bus.rd_en), 0);
    chk("abort_wr_en", 32'(bus.wr_en), 0);
    chk("abort_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    repeat (20) begin @(posedge clk); #1; end
    chk("abort_no_done", 32'(done_cnt), 0);
    start_transform();
    wait_done(3000);

    // Reset in the middle of stage 2, then start on the first cycle out of reset.
    mem_mode = 1'b1;
    @(posedge clk); #1;
    start_transform();
    n = 0;
    while (!(cur_stage == 4'd2 && rd_cnt >= 300) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reset_point_reached", 32'(cur_stage), 2);
    rst_n    = 1'b0;
    mem_mode = 1'b0;
    @(posedge clk); #1;
    exp_rd.delete();
    exp_wr.delete();
    last_a  = '0;
    last_b  = '0;
    last_tw = '0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_transform();
    wait_done(3000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 4, butterfly datapath latency in cycles from read issue to writeback (legal range 1..8).
REQ-002 SHALL have parameter N_LOG2, default 8, log2 of FFT length (256 points, 128 butterflies per stage, 8 stages).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  begin a transform; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the transform in progress.
REQ-007 SHALL have port mem_ready  input  1  memory can accept a read this cycle; low stalls issue.
REQ-008 SHALL have port rd_en  output  1  butterfly read issued this cycle.
REQ-009 SHALL have port rd_addr_a, rd_addr_b  output  8 each  upper and lower butterfly operand addresses.
REQ-010 SHALL have port tw_addr  output  7  twiddle ROM address for the issued butterfly.
REQ-011 SHALL have port stage_idx  output  3  current stage, 0..7.
REQ-012 SHALL have port wr_en  output  1  writeback of a completed butterfly this cycle.
REQ-013 SHALL have port wr_addr_a, wr_addr_b  output  8 each  writeback addresses.
REQ-014 SHALL have port busy  output  1  high in RUN, DRAIN and DONE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at transform completion.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE: start=1 -> RUN with stage_idx=0 and k=0; start is ignored in every other state.
REQ-018 RUN: rd_en = mem_ready (combinational); each cycle with rd_en=1 issues butterfly k and increments k; mem_ready=0 holds k and all address outputs.
REQ-019 Address rule, radix-2 DIT with s=stage_idx, half=1<<s, grp=k>>s, pos=k&(half-1): rd_addr_a=(grp<<(s+1))|pos, rd_addr_b=rd_addr_a+half, tw_addr=pos<<(7-s).
REQ-020 The cycle that issues k=127 SHALL transition RUN -> DRAIN, and k SHALL wrap to 0.
REQ-021 Writeback delay line: for each issue at cycle t, wr_en=1 at cycle t+PIPE_LAT with wr_addr_a/b equal to the issued rd_addr_a/b. The delay line is never stalled by mem_ready.
REQ-022 An in-flight counter SHALL increment on issue and decrement on wr_en; when both occur in the same cycle it is unchanged.
REQ-023 DRAIN: rd_en=0; when in-flight==0 -> DONE if stage_idx==7, else -> RUN with stage_idx+1 on the next cycle. Stages never overlap (read-after-write barrier).
REQ-024 With no stalls, the first rd_en of stage s+1 SHALL occur exactly PIPE_LAT+2 cycles after the last rd_en of stage s.
REQ-025 DONE: done=1 for exactly one cycle, then -> IDLE; busy=0 from that next cycle.
REQ-026 abort=1 in any non-IDLE state -> IDLE next cycle: delay line flushed (no further wr_en), in-flight=0, done not asserted. abort has priority over every other transition; abort in IDLE has no effect.
REQ-027 When rd_en=0, rd_addr_a/b and tw_addr SHALL hold their last values; outputs are otherwise don't-care but X-free.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, stage_idx=0, k=0, in-flight=0, delay line cleared, and rd_en=wr_en=busy=done=0, all addresses 0. This applies mid-transform, with no wr_en afterwards.
REQ-029 After rst_n returns high, the block SHALL be ready to accept start on the first cycle.

Verification
REQ-030 Reset, start at cycle 0, mem_ready=1 constant, PIPE_LAT=4 -> stage 0 issues k=0: a=0/b=1/tw=0 at cycle 1; k=1: a=2/b=3/tw=0; done pulses at cycle 1065; exactly 1024 rd_en and 1024 wr_en.
REQ-031 Stage 3, k=9 -> rd_addr_a=17, rd_addr_b=25, tw_addr=16; stage 7, k=127 -> a=127, b=255, tw=127.
REQ-032 Random mem_ready toggling (about 30% low) -> same address/twiddle sequence as REQ-030, rd_en count per stage=128, every wr_en exactly PIPE_LAT cycles after its issue, no stage's first read before the prior stage's last write.
REQ-033 abort during stage 4 DRAIN with 3 ops in flight -> IDLE next cycle, zero further wr_en, done=0; new start then runs a full transform from stage 0.
REQ-034 rst_n=0 mid-stage 2 -> all outputs 0 next cycle; start pulsed while busy -> ignored, transform completes normally with a single done pulse.
